// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sequences reads of a block-RAM address window and streams samples out
// through a small skid FIFO, with single-pass or looped playback.
module bram_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              loop_en,
    input  logic              stop,
    output logic [ADDR_W-1:0] raddr,
    output logic              read_en,
    output logic              rclke,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_D);
    localparam int CW = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
    logic              loop_q, loop_d, done_q, done_d;
    logic              rv_q, rv_last_q;
    logic [DATA_W-1:0] mem_data_q [FIFO_D];
    logic              mem_last_q [FIFO_D];
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     fc_q, fc_d;
    logic              re, last_rd, pop, pop_mem, push_mem;

    // The word on rdata is visible at the output immediately and only lands in storage if not taken.
    assign m_valid = (fc_q != '0) || rv_q;
    assign m_data  = (fc_q != '0) ? mem_data_q[rp_q] : (rv_q ? rdata : '0);
    assign m_last  = (fc_q != '0) ? mem_last_q[rp_q] : (rv_q && rv_last_q);
    assign read_en = re;
    assign rclke   = re;
    assign raddr   = cur_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;

    always_comb begin
        re       = (state_q == RUN) && ((32'(fc_q) + 32'(rv_q)) < 32'(FIFO_D));
        last_rd  = cnt_q == len_q - (ADDR_W + 1)'(1);
        pop      = m_valid && m_ready;
        pop_mem  = pop && (fc_q != '0);
        push_mem = rv_q && !(pop && (fc_q == '0));
        fc_d     = fc_q + CW'(push_mem) - CW'(pop_mem);
        state_d  = state_q;
        cur_d    = cur_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        loop_d   = loop_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                base_d  = start_addr;
                cur_d   = start_addr;
                len_d   = (length == '0) ? (ADDR_W + 1)'(2 ** ADDR_W) : length;
                cnt_d   = '0;
                loop_d  = loop_en;
            end
            RUN: begin
                if (re) begin
                    cur_d = last_rd ? base_q : cur_q + ADDR_W'(1);
                    cnt_d = last_rd ? '0 : cnt_q + (ADDR_W + 1)'(1);
                    if (last_rd && !loop_q) state_d = DRAIN;
                end
                if (stop) state_d = DRAIN;
            end
            DRAIN: if (fc_d == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            rv_last_q <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            loop_q    <= loop_d;
            done_q    <= done_d;
            rv_q      <= re;
            rv_last_q <= re && last_rd;
            wp_q      <= wp_q + PW'(push_mem);
            rp_q      <= rp_q + PW'(pop_mem);
            fc_q      <= fc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_mem) begin
            mem_data_q[wp_q] <= rdata;
            mem_last_q[wp_q] <= rv_last_q;
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: random RAM contents, directed and random playback runs checked
// against an index-based model of the expected address/sample stream.
module tb_bram_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n, start, loop_en, stop, m_ready;
    logic [7:0]  start_addr, raddr;
    logic [8:0]  length;
    logic        read_en, rclke, m_valid, m_last, busy, done;
    logic [15:0] rdata, m_data;
    logic [15:0] ram [256];

    int total = 0, bad = 0;
    int cyc = 0, run_addr = 0, run_len = 1, idx = 0, rd_idx = 0;
    int issued = 0, popped = 0, max_out = 0, done_cnt = 0;
    int start_cyc = 0, first_re = -1, first_v = -1, last_pop = -1;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [15:0] prev_data = '0;

    bram_stream_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
        .loop_en(loop_en), .stop(stop), .raddr(raddr), .read_en(read_en), .rclke(rclke),
        .rdata(rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (read_en) rdata <= ram[raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected stream: word i of a run comes from address start + (i mod len), last when i mod len == len-1.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (start && !busy) begin
                run_addr = int'(start_addr);
                run_len = (length == 0) ? 256 : int'(length);
                idx = 0; rd_idx = 0; issued = 0; popped = 0; max_out = 0; done_cnt = 0;
                start_cyc = cyc; first_re = -1; first_v = -1; last_pop = -1;
            end
            if (read_en) begin
                check("raddr", 32'(raddr), 32'((run_addr + rd_idx % run_len) % 256));
                check("rclke", 32'(rclke), 32'd1);
                if (first_re < 0) first_re = cyc;
                rd_idx++;
                issued++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (prev_stall) check("stable", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                check("data", 32'(m_data), 32'(ram[(run_addr + idx % run_len) % 256]));
                check("last", 32'(m_last), 32'((idx % run_len) == run_len - 1));
                idx++;
                popped++;
                last_pop = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] a, input logic [8:0] l, input logic lp, input logic with_stop);
        start_addr = a; length = l; loop_en = lp; start = 1'b1; stop = with_stop;
        tick();
        start = 1'b0; stop = 1'b0;
    endtask

    // rmode: 0 hold m_ready, 1 toggle each cycle, 2 random
    task automatic wait_idle(input int maxc, input int rmode);
        int n = 0;
        while (busy && n < maxc) begin
            if (rmode == 1) m_ready = ~m_ready;
            if (rmode == 2) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (busy) check("timeout", 32'(busy), 32'd0);
        m_ready = 1'b1;
        tick();
    endtask

    task automatic end_run(input int exp_n);
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        if (exp_n >= 0) check("count", 32'(idx), 32'(exp_n));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; m_ready = 1'b1;
        start_addr = '0; length = '0;
        tick(); tick();
        check("rst_read_en", 32'(read_en), 0);
        check("rst_raddr", 32'(raddr), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_idle", 32'(busy), 0);

        go(8'h10, 9'd4, 1'b0, 1'b0);
        wait_idle(50, 0);
        end_run(4);
        check("first_re", 32'(first_re - start_cyc), 1);
        check("first_valid", 32'(first_v - start_cyc), 2);
        check("last_valid", 32'(last_pop - start_cyc), 5);

        go(8'hFE, 9'd4, 1'b0, 1'b0);
        wait_idle(50, 0);
        end_run(4);

        go(8'h40, 9'd8, 1'b0, 1'b0);
        wait_idle(100, 1);
        end_run(8);
        check("max_buf", 32'(max_out <= 2), 1);

        begin
            int n = 0;
            go(8'h20, 9'd3, 1'b1, 1'b0);
            while (idx < 7 && n < 100) begin tick(); n++; end
            stop = 1'b1;
            tick();
            stop = 1'b0;
            wait_idle(50, 0);
            end_run(-1);
            check("loop_cnt", 32'(idx >= 7 && idx <= 10), 1);
        end

        go(8'hC3, 9'd0, 1'b0, 1'b1);
        repeat (10) tick();
        start_addr = 8'h55; length = 9'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(400, 0);
        end_run(256);

        m_ready = 1'b0;
        go(8'h80, 9'd8, 1'b0, 1'b0);
        repeat (6) tick();
        check("full_valid", 32'(m_valid), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_re", 32'(read_en), 0);
        check("mid_rst_raddr", 32'(raddr), 0);
        check("mid_rst_valid", 32'(m_valid), 0);
        check("mid_rst_data", 32'(m_data), 0);
        check("mid_rst_last", 32'(m_last), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        rst_n = 1'b1; m_ready = 1'b1;
        tick();
        check("no_done_after_rst", 32'(done), 0);
        go(8'h33, 9'd5, 1'b0, 1'b0);
        wait_idle(50, 0);
        end_run(5);

        for (int r = 0; r < 6; r++) begin
            int l = $urandom_range(1, 20);
            go(8'($urandom), 9'(l), 1'b0, 1'b0);
            wait_idle(300, 2);
            end_run(l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
